// File: rtl/pcihellocore_ex_input_pio_debounce.sv
// Avalon-MM input PIO: synchronises and debounces in_port, captures the selected
// edge per bit, and raises a maskable level interrupt. Map: 0 data, 2 mask, 3 edge capture.
module pcihellocore_ex_input_pio_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int PW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] RELOAD = PW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] samp_prev_q, samp_prev_d;
  logic [WIDTH-1:0] debounced_q, debounced_d;
  logic [WIDTH-1:0] deb_d_q, deb_d_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [PW-1:0]    prescaler_q, prescaler_d;

  logic             tick;
  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] edge_hit;
  logic             unused_wdata;

  // Upper writedata bits are deliberately ignored.
  assign unused_wdata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign tick    = (prescaler_q == '0);

  always_comb begin
    sync1_d        = in_port;
    sync2_d        = sync1_q;
    prescaler_d    = tick ? RELOAD : prescaler_q - 1'b1;
    samp_prev_d    = samp_prev_q;
    debounced_d    = debounced_q;
    deb_d_d        = debounced_q;
    irq_mask_d     = irq_mask_q;
    edge_capture_d = edge_capture_q;
    edge_hit       = '0;

    // A bit only moves once the same level is seen on two consecutive ticks.
    if (tick) begin
      samp_prev_d = sync2_q;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == samp_prev_q[i]) debounced_d[i] = sync2_q[i];
      end
    end

    case (EDGE_MODE)
      0:       edge_hit = debounced_q & ~deb_d_q;
      1:       edge_hit = ~debounced_q & deb_d_q;
      default: edge_hit = debounced_q ^ deb_d_q;
    endcase

    // Clear first, then set, so a coincident edge survives the clearing write.
    if (wr_en && address == 2'd3) edge_capture_d = edge_capture_d & ~wr_bits;
    edge_capture_d = edge_capture_d | edge_hit;

    if (wr_en && address == 2'd2) irq_mask_d = wr_bits;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      samp_prev_q    <= '0;
      debounced_q    <= '0;
      deb_d_q        <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      prescaler_q    <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      samp_prev_q    <= samp_prev_d;
      debounced_q    <= debounced_d;
      deb_d_q        <= deb_d_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      prescaler_q    <= prescaler_d;
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = debounced_q;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_capture_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pcihellocore_ex_input_pio_debounce.sv
// Bench for the debounced input PIO: directed scenarios plus random traffic,
// checked against a pin-history reference model through an expected queue.
module tb_pcihellocore_ex_input_pio_debounce;

  localparam int WIDTH = 4;
  localparam int D     = 4;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'd0;
  logic [3:0]  in_port    = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  pcihellocore_ex_input_pio_debounce #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(D), .EDGE_MODE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A pin value seen at clock k reaches the sampler at clock k+2; ticks fall on
  // every D-th clock after reset release, starting with the first one.
  int         m_n = 0;
  logic [3:0] hist[$];
  logic [3:0] m_deb = 4'h0, m_deb_last = 4'h0, m_ec = 4'h0, m_mask = 4'h0;

  function automatic logic [3:0] pin_at(input int k);
    if (k < 0) return 4'h0;
    return hist[k];
  endfunction

  function automatic void model_step();
    logic [3:0] now_s, prev_s, nd, fall, clr;
    hist.push_back(in_port);
    nd = m_deb;
    if (m_n % D == 0) begin
      now_s  = pin_at(m_n - 2);
      prev_s = pin_at(m_n - D - 2);
      for (int i = 0; i < 4; i++)
        if (now_s[i] == prev_s[i]) nd[i] = now_s[i];
    end
    fall = ~m_deb & m_deb_last;
    clr  = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
    m_ec = (m_ec & ~clr) | fall;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
    m_deb_last = m_deb;
    m_deb      = nd;
    m_n++;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_n = 0; hist.delete();
      m_deb = 0; m_deb_last = 0; m_ec = 0; m_mask = 0;
    end else begin
      model_step();
    end
  end

  function automatic logic [32:0] model_exp(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0: r[3:0] = m_deb;
      2'd2: r[3:0] = m_mask;
      2'd3: r[3:0] = m_ec;
      default: r = 32'd0;
    endcase
    return {|(m_ec & m_mask), r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  string       name_q[$];
  event        rd_evt;

  always begin
    logic [32:0] got, e;
    string nm;
    @(rd_evt);
    got = {irq, readdata};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL queue_underflow got irq=%0b rd=%h", got[32], got[31:0]);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s addr=%0d got irq=%0b rd=%h expected irq=%0b rd=%h",
                 nm, address, got[32], got[31:0], e[32], e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input logic [1:0] a, input logic [32:0] e, input string nm);
    address = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1 ->rd_evt;
    #1;
  endtask

  task automatic rd_now(input logic [1:0] a, input string nm);
    chk(a, model_exp(a), nm);
  endtask

  task automatic rd(input logic [1:0] a, input string nm);
    @(negedge clk);
    rd_now(a, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((m_n % D) != p && guard < 2 * D) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] f;
    bit found;

    // Reset held with all inputs high.
    repeat (2) @(negedge clk);
    chk(2'd0, 33'h0, "reset_addr0");
    @(negedge clk); chk(2'd2, 33'h0, "reset_addr2");
    @(negedge clk); chk(2'd3, 33'h0, "reset_addr3");
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 10; i++) rd(2'd0, "release_track");
    chk(2'd0, {1'b0, 32'h0000_000F}, "release_deb_F");
    rd(2'd3, "release_ec");
    chk(2'd3, 33'h0, "release_no_edge");

    // Falling edge on bit 0, mask still closed.
    @(negedge clk); in_port = 4'hE;
    for (int i = 0; i < 9; i++) rd(2'd0, "fall0_track");
    @(negedge clk); chk(2'd0, {1'b0, 32'h0000_000E}, "fall0_deb_E");
    @(negedge clk); chk(2'd3, {1'b0, 32'h0000_0001}, "fall0_ec");
    wr(2'd2, 32'h1);
    chk(2'd3, {1'b1, 32'h0000_0001}, "mask_irq_on");

    // Three-clock glitch on bit 1 placed between sample points.
    wait_phase(3);
    in_port[1] = 1'b0;
    repeat (3) @(negedge clk);
    in_port[1] = 1'b1;
    for (int i = 0; i < 12; i++) rd(2'd0, "glitch_track");
    @(negedge clk); chk(2'd0, {1'b1, 32'h0000_000E}, "glitch_deb");
    @(negedge clk); chk(2'd3, {1'b1, 32'h0000_0001}, "glitch_ec");

    // Clear by W1C.
    wr(2'd3, 32'h1);
    chk(2'd3, 33'h0, "clear_ec");

    // Clear colliding with a new fall on bit 0: set wins.
    @(negedge clk); in_port = 4'hF;
    for (int i = 0; i < 12; i++) rd(2'd0, "rise0_track");
    @(negedge clk); chk(2'd3, 33'h0, "rise_not_captured");
    in_port = 4'hE;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      f = ~m_deb & m_deb_last;
      if (f[0]) begin
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        found = 1'b1;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL collide_timeout got no fall within 20 clk expected one");
    end
    chk(2'd3, {1'b1, 32'h0000_0001}, "collide_set_wins");

    // Mask width and ignored writes.
    wr(2'd2, 32'hFFFF_FFFF);
    chk(2'd2, {1'b1, 32'h0000_000F}, "mask_width");
    wr(2'd0, 32'h5);
    wr(2'd1, 32'hA);
    chk(2'd0, {1'b1, 32'h0000_000E}, "ignored_addr0");
    @(negedge clk); chk(2'd1, {1'b1, 32'h0}, "addr1_zero");
    @(negedge clk); chk(2'd2, {1'b1, 32'h0000_000F}, "ignored_mask");

    // Reset mid-operation with edge_capture = 3.
    @(negedge clk); in_port = 4'hC;
    for (int i = 0; i < 12; i++) rd(2'd3, "fall1_track");
    @(negedge clk); chk(2'd3, {1'b1, 32'h0000_0003}, "pre_reset_ec");
    @(negedge clk); reset_n = 1'b0;
    chk(2'd3, 33'h0, "async_irq_drop");
    @(negedge clk); reset_n = 1'b1;
    chk(2'd0, 33'h0, "post_reset_addr0");
    @(negedge clk); chk(2'd2, 33'h0, "post_reset_addr2");
    @(negedge clk); chk(2'd3, 33'h0, "post_reset_addr3");

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          @(negedge clk);
          in_port = $urandom_range(0, 15);
          for (int k = 0; k < int'($urandom_range(1, 10)); k++)
            rd(2'($urandom_range(0, 3)), "rand_hold");
        end
        3: begin
          @(negedge clk);
          in_port[$urandom_range(0, 3)] ^= 1'b1;
          rd(2'($urandom_range(0, 3)), "rand_glitch");
        end
        4: begin wr(2'd2, $urandom()); rd_now(2'd2, "rand_mask"); end
        5: begin wr(2'd3, $urandom()); rd_now(2'd3, "rand_clear"); end
        6: begin wr(2'($urandom_range(0, 1)), $urandom()); rd_now(2'd0, "rand_ignored"); end
        default: rd(2'($urandom_range(0, 3)), "rand_read");
      endcase
    end

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
